// File: rtl/rng_code_picker.sv
// rng_code_picker: builds a multi-digit code from an LFSR nibble by rejection sampling.
// Samples rng_in[3:0] every SAMPLE_GAP cycles and aborts after MAX_REJECT misses in a row.
module rng_code_picker #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_MAX  = 9,
    parameter int UNIQUE     = 1,
    parameter int SAMPLE_GAP = 4,
    parameter int MAX_REJECT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             rng_in,
    input  logic                    req,
    output logic                    busy,
    output logic                    done,
    output logic                    code_valid,
    output logic                    err,
    output logic [4*NUM_DIGITS-1:0] code
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_SAMPLE = 1'b1;

    localparam logic [3:0] GAP_LOAD  = 4'(SAMPLE_GAP - 1);
    localparam logic [3:0] MAX_DIGIT = 4'(DIGIT_MAX);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_DIGITS - 1);
    localparam logic [7:0] LAST_REJ  = 8'(MAX_REJECT - 1);

    logic [0:0]              state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    code_valid_q, code_valid_d;
    logic                    err_q, err_d;
    logic [4*NUM_DIGITS-1:0] code_q, code_d;
    logic [3:0]              gap_q, gap_d;
    logic [3:0]              idx_q, idx_d;
    logic [7:0]              rej_q, rej_d;

    logic [3:0] nib;
    logic       dup;
    logic       legal;
    logic       rng_unused;

    assign nib        = rng_in[3:0];
    assign rng_unused = ^rng_in[15:4];

    // Only digits already stored (below idx_q) count; cleared slots hold a legal 0.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (UNIQUE != 0 && i < int'(idx_q) && code_q[4*i +: 4] == nib) begin
                dup = 1'b1;
            end
        end
    end

    assign legal = (nib <= MAX_DIGIT) && !dup;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        code_valid_d = code_valid_q;
        err_d        = err_q;
        code_d       = code_q;
        gap_d        = gap_q;
        idx_d        = idx_q;
        rej_d        = rej_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d      = S_SAMPLE;
                    busy_d       = 1'b1;
                    code_d       = '0;
                    code_valid_d = 1'b0;
                    err_d        = 1'b0;
                    idx_d        = '0;
                    rej_d        = '0;
                    gap_d        = GAP_LOAD;
                end
            end
            S_SAMPLE: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else begin
                    gap_d = GAP_LOAD;
                    if (legal) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (i == int'(idx_q)) begin
                                code_d[4*i +: 4] = nib;
                            end
                        end
                        idx_d = idx_q + 4'd1;
                        rej_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d      = S_IDLE;
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                            code_valid_d = 1'b1;
                        end
                    end else begin
                        rej_d = rej_q + 8'd1;
                        if (rej_q == LAST_REJ) begin
                            state_d      = S_IDLE;
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                            err_d        = 1'b1;
                            code_d       = '0;
                            code_valid_d = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
            gap_q        <= '0;
            idx_q        <= '0;
            rej_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
            code_q       <= code_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            rej_q        <= rej_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign code_valid = code_valid_q;
    assign err        = err_q;
    assign code       = code_q;

endmodule

// File: doc/rng_code_picker.md
# rng_code_picker

Consumer end of the 16-bit free-running LFSR random source. On request, samples the LFSR output at fixed intervals and uses rejection sampling to build a multi-digit random code, with optionally distinct digits, for the game's bomb-defuse code. Sits between the LFSR counter and the game controller FSM. Reports a one-cycle completion pulse, and an error flag if the random source appears stuck.

## Interface
- NUM_DIGITS, 4, number of 4-bit digits in the code (1..8)
- DIGIT_MAX, 9, largest legal digit value (0..15)
- UNIQUE, 1, 1 = all digits in one code must be distinct (requires DIGIT_MAX+1 >= NUM_DIGITS)
- SAMPLE_GAP, 4, clock cycles between successive samples (1..16); 4 gives fresh nibbles from a 1-bit-per-cycle shifter
- MAX_REJECT, 64, consecutive rejections that abort a request (2..255)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rng_in  in  16  LFSR value; only rng_in[3:0] is used
- req  in  1  level request; accepted only in IDLE
- busy  out  1  high while a code is being built
- done  out  1  one-cycle pulse at completion or abort
- code_valid  out  1  high from a successful completion until the next accepted request
- err  out  1  high from an abort until the next accepted request
- code  out  4*NUM_DIGITS  digit i at code[4i+3:4i]; digit 0 is sampled first

## Operation
- Reset: state IDLE. busy, done, code_valid, err = 0. code = 0. gap counter, digit index and reject counter = 0.
- States: IDLE, SAMPLE.
- IDLE, req=1 at edge k (accept):
  - state <= SAMPLE; busy <= 1.
  - code <= 0; code_valid <= 0; err <= 0.
  - digit index <= 0; reject count <= 0; gap <= SAMPLE_GAP-1.
- SAMPLE, gap != 0: gap <= gap-1; no evaluation.
- SAMPLE, gap == 0: evaluate n = rng_in[3:0]; gap <= SAMPLE_GAP-1.
  - Reject if n > DIGIT_MAX.
  - Reject if UNIQUE=1 and n equals any already-stored digit 0..index-1.
  - Accept: store n at the current index; index++; reject count <= 0.
  - Reject: reject count++.
- Completion, same edge the last digit is stored: state <= IDLE; busy <= 0; done <= 1; code_valid <= 1.
- Abort, same edge the reject count reaches MAX_REJECT: state <= IDLE; busy <= 0; done <= 1; err <= 1; code <= 0; code_valid <= 0.
- done is high for exactly one cycle, then returns to 0.
- req is ignored while busy. Holding req high in IDLE starts a new request on the cycle after done.
- A stuck source (all-zero or constant nibble) must end in abort, never hang.

## Timing
- Accept at edge k; busy is high from k.
- Evaluations occur at edges k+SAMPLE_GAP·j, for j = 1, 2, ...
- Minimum latency with no rejections: done at edge k+NUM_DIGITS·SAMPLE_GAP. Defaults: k+16.
- Worst case: abort at edge k+SAMPLE_GAP·(NUM_DIGITS-1+MAX_REJECT).
- code and code_valid change only at accept, completion or abort edges. code is stable while code_valid=1.
- rst=1 mid-operation: at the next edge, everything returns to reset values, regardless of req. No done pulse is issued.
- rst and req both high: reset wins.

## Test plan
- Reset: assert rst 2 cycles with req=1 -> busy, done, code_valid, err = 0 and code = 0 throughout. No accept occurs while rst=1.
- Clean pick (defaults): accept at edge k; bench drives rng_in[3:0] = 3, 7, 1, 9 at the four evaluation edges -> done at k+16, code = 16'h9173, code_valid = 1, err = 0.
- Range and duplicate rejection (defaults): evaluation nibbles 12, 3, 3, 15, 5, 0, 8 -> accepted digits 3, 5, 0, 8; done at k+28; code = 16'h8053.
- UNIQUE=0: nibbles 4, 4, 4, 4 -> code = 16'h4444 at k+16.
- Stuck source: rng_in = 16'h000F constant -> first evaluation accepts nothing; every evaluation rejects; abort at k+4·64 with err = 1, code = 0, done pulsed once.
- rst at k+6 mid-pick, then req held high -> all outputs 0 on the reset edge. New accept on the first edge with rst=0. Subsequent normal completion matches the clean-pick timing.
